// File: rtl/rosc_toggle_meter_if.sv
// Control and result bundle of the ring-oscillator toggle meter.
// The slave side is the meter; the master side is the health-test consumer.
interface rosc_toggle_meter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [31:0]      window;
  logic             busy;
  logic             count_valid;
  logic             count_ready;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output start, window, count_ready,
    input  busy, count_valid, count, overflow
  );

  modport slave (
    input  start, window, count_ready,
    output busy, count_valid, count, overflow
  );
endinterface

// File: rtl/rosc_toggle_meter.sv
// Counts din toggles over a window of enb cycles; result valid window+1 cycles after start (enb held high).
// Result is held in HOLD until count_ready; a start in the handshake cycle re-arms without passing through IDLE.
module rosc_toggle_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enb,
  input  logic din,
  rosc_toggle_meter_if.slave mtr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ds;
  logic                   prev_q, prev_d;
  logic [31:0]            remaining_q, remaining_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   arm;

  // din is asynchronous to clk, so it passes a plain flop chain before any use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign ds = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= 1'b0;
      remaining_q <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    arm         = mtr.start && (mtr.window != 32'd0);

    case (state_q)
      IDLE: begin
        if (arm) begin
          remaining_d = mtr.window;
          prev_d      = ds;
          count_d     = '0;
          ovf_d       = 1'b0;
          state_d     = MEASURE;
        end
      end

      MEASURE: begin
        if (enb) begin
          prev_d      = ds;
          remaining_d = remaining_q - 32'd1;
          if (ds != prev_q) begin
            if (count_q == CNT_MAX) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
          if (remaining_q == 32'd1) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (mtr.count_ready) begin
          if (arm) begin
            remaining_d = mtr.window;
            prev_d      = ds;
            count_d     = '0;
            ovf_d       = 1'b0;
            state_d     = MEASURE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mtr.busy        = (state_q == MEASURE);
  assign mtr.count_valid = (state_q == HOLD);
  assign mtr.count       = count_q;
  assign mtr.overflow    = ovf_q;

endmodule

// File: tb/tb_rosc_toggle_meter.sv
// Bench for rosc_toggle_meter: a 16-bit and a 4-bit instance share one stimulus stream,
// results are predicted per vector and checked against a scoreboard queue.
module tb_rosc_toggle_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enb = 1'b0;
  logic        din = 1'b0;
  logic        start = 1'b0;
  logic [31:0] window = '0;
  logic        count_ready = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rosc_toggle_meter_if #(.CNT_W(16)) b16 ();
  rosc_toggle_meter_if #(.CNT_W(4))  b4 ();

  assign b16.start       = start;
  assign b16.window      = window;
  assign b16.count_ready = count_ready;
  assign b4.start        = start;
  assign b4.window       = window;
  assign b4.count_ready  = count_ready;

  rosc_toggle_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .enb   (enb),
    .din   (din),
    .mtr   (b16)
  );

  rosc_toggle_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .enb   (enb),
    .din   (din),
    .mtr   (b4)
  );

  typedef struct {
    logic [31:0] window;
    int          din_mode;  // 0: toggle every cycle, 1: every 2 cycles, 2: held at 1
    int          enb_mode;  // 0: enb held high, 1: alternating, low on the first cycle after start
    int          rdy_dly;
    int          c16;
    int          o16;
    int          c4;
    int          o4;
    int          lat;
    int          nbusy;
  } vec_t;

  typedef struct {
    int t;
    int c16;
    int o16;
    int c4;
    int o4;
    int lat;
    int nbusy;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  int din_mode = 0;
  int enb_mode = 0;
  int t_start  = 0;
  int busy_n   = 0;
  bit vld_prev = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (din_mode)
      0:       din = cyc[0];
      1:       din = cyc[1];
      default: din = 1'b1;
    endcase
    enb = (enb_mode == 0) ? 1'b1 : (((cyc - t_start) % 2) == 0);
  endtask

  task automatic do_start(logic [31:0] w, exp_t e);
    start   = 1'b1;
    window  = w;
    t_start = cyc;
    e.t     = cyc;
    sb.push_back(e);
  endtask

  // Waits for count_valid, holds count_ready low for dly valid cycles, then handshakes;
  // a nonzero rw re-arms in the handshake cycle.
  task automatic wait_result(int dly, logic [31:0] rw, exp_t e2);
    int n = 0;
    int budget = 0;
    bit done = 1'b0;
    while (!done) begin
      step();
      count_ready = 1'b0;
      window      = $urandom;
      start       = (b16.busy || b16.count_valid) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (b16.count_valid) begin
        if (n == dly) begin
          count_ready = 1'b1;
          start       = 1'b0;
          done        = 1'b1;
          if (rw != 32'd0) do_start(rw, e2);
        end
        n++;
      end
      budget++;
      if (budget > 1000) begin
        n_chk++;
        n_fail++;
        $display("FAIL wait_valid: no count_valid within 1000 cycles (cycle %0d)", cyc);
        done = 1'b1;
      end
    end
  endtask

  task automatic close_xfer();
    step();
    count_ready = 1'b0;
    start       = 1'b0;
  endtask

  // Scoreboard side: compares the front expectation whenever a result is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() == 0) begin
        chk("no_spurious_valid16", b16.count_valid, 0);
        chk("no_spurious_valid4", b4.count_valid, 0);
      end else begin
        if (b16.busy) busy_n++;
        if (b16.count_valid && !vld_prev) begin
          chk("latency", cyc - sb[0].t, sb[0].lat);
          chk("busy_cycles", busy_n, sb[0].nbusy);
        end
        if (b16.count_valid) begin
          chk("count16", b16.count, sb[0].c16);
          chk("overflow16", b16.overflow, sb[0].o16);
          chk("valid4", b4.count_valid, 1);
          chk("count4", b4.count, sb[0].c4);
          chk("overflow4", b4.overflow, sb[0].o4);
        end
        if (b16.count_valid && count_ready) begin
          void'(sb.pop_front());
          busy_n = 0;
        end
      end
      vld_prev = b16.count_valid;
    end
  end

  initial begin
    exp_t e;
    exp_t ez;

    vecs[0] = '{32'd10,  0, 0, 0, 10,  0, 10, 0, 11,  10};
    vecs[1] = '{32'd8,   2, 0, 2, 0,   0, 0,  0, 9,   8};
    vecs[2] = '{32'd20,  0, 0, 1, 20,  0, 15, 1, 21,  20};
    vecs[3] = '{32'd4,   0, 1, 0, 0,   0, 0,  0, 9,   8};
    vecs[4] = '{32'd4,   1, 1, 5, 4,   0, 4,  0, 9,   8};
    vecs[5] = '{32'd1,   0, 0, 0, 1,   0, 1,  0, 2,   1};
    vecs[6] = '{32'd6,   1, 0, 3, 3,   0, 3,  0, 7,   6};
    vecs[7] = '{32'd16,  0, 0, 0, 16,  0, 15, 1, 17,  16};
    vecs[8] = '{32'd300, 0, 0, 1, 300, 0, 15, 1, 301, 300};
    vecs[9] = '{32'd15,  0, 0, 0, 15,  0, 15, 0, 16,  15};
    ez = '{0, 0, 0, 0, 0, 0, 0};

    #2;
    chk("rst_busy", b16.busy, 0);
    chk("rst_valid", b16.count_valid, 0);
    chk("rst_count", b16.count, 0);
    chk("rst_overflow", b16.overflow, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      din_mode = vecs[i].din_mode;
      enb_mode = vecs[i].enb_mode;
      repeat (4) step();
      e = '{0, vecs[i].c16, vecs[i].o16, vecs[i].c4, vecs[i].o4, vecs[i].lat, vecs[i].nbusy};
      do_start(vecs[i].window, e);
      wait_result(vecs[i].rdy_dly, 32'd0, ez);
      close_xfer();
    end

    // window=0 in IDLE is ignored and the last result stays on count
    step();
    start  = 1'b1;
    window = 32'd0;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("win0_busy", b16.busy, 0);
    chk("win0_valid", b16.count_valid, 0);
    chk("win0_count_kept", b16.count, 15);
    step();
    @(negedge clk);
    chk("win0_busy_later", b16.busy, 0);

    // Back-to-back: 5 stalled valid cycles, then re-arm with window=3 in the handshake cycle
    din_mode = 0;
    enb_mode = 0;
    repeat (4) step();
    e = '{0, 5, 0, 5, 0, 6, 5};
    do_start(32'd5, e);
    e = '{0, 3, 0, 3, 0, 4, 3};
    wait_result(5, 32'd3, e);
    step();
    count_ready = 1'b0;
    start       = 1'b0;
    @(negedge clk);
    chk("rearm_busy", b16.busy, 1);
    chk("rearm_valid", b16.count_valid, 0);
    wait_result(0, 32'd0, ez);
    close_xfer();

    // Full-range window never wraps; reset mid-MEASURE aborts immediately
    repeat (4) step();
    e = '{0, 0, 0, 0, 0, 0, 0};
    do_start(32'hFFFF_FFFF, e);
    step();
    start = 1'b0;
    repeat (4) step();
    chk("maxwin_busy", b16.busy, 1);
    chk("maxwin_count_mid", b16.count, 4);
    #2;
    rst_n = 1'b0;
    sb.delete();
    busy_n   = 0;
    vld_prev = 1'b0;
    #1;
    chk("arst_busy", b16.busy, 0);
    chk("arst_valid", b16.count_valid, 0);
    chk("arst_count", b16.count, 0);
    chk("arst_overflow", b16.overflow, 0);
    chk("arst_busy4", b4.busy, 0);
    #3 rst_n = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("post_rst_busy", b16.busy, 0);
    chk("post_rst_valid", b16.count_valid, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
